// File: rtl/seg_scan_controller_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package : seg_pkg
//  Purpose : Shared types, segment bit positions and the hex-to-segment
//            decoder used by the multiplexed 7-segment scan controller.
//  Ports   : (package - none)
//  Rev     : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Pattern layout {dp,g,f,e,d,c,b,a}, active-high (1 = segment lit).
    typedef logic [7:0] seg_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs 0-9, A, b, C, d, E, F; decimal point always off.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        s[SEG_DP] = 1'b0;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_controller_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : seg_tick_gen
//  Purpose : Slot timing for the scan controller. Counts clock cycles within
//            a digit slot (0..DIGIT_CYC-1) and the PWM phase within the slot.
//  Ports   : clk, rst       - clock, async active-high reset
//            cyc            - cycle index within the current slot
//            phase          - cyc / PHASE_CYC
//            slot_start     - cyc == 0
//            slot_end       - cyc == DIGIT_CYC-1 (slot wraps on next clock)
//  Rev     : 1.0  initial release
// ============================================================================
module seg_tick_gen #(
    parameter int DIGIT_CYC = 16,
    parameter int PHASE_CYC = 4,
    parameter int BRIGHT_W  = 2,
    parameter int CNT_W     = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1,
    parameter int PCNT_W    = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [CNT_W-1:0]    cyc,
    output logic [BRIGHT_W-1:0] phase,
    output logic                slot_start,
    output logic                slot_end
);

    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(DIGIT_CYC - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_CYC - 1);

    // Sub-counter within a phase; avoids a divider for cyc / PHASE_CYC.
    logic [PCNT_W-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc   <= '0;
            pcnt  <= '0;
            phase <= '0;
        end else if (cyc == CYC_LAST) begin
            cyc   <= '0;
            pcnt  <= '0;
            phase <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (pcnt == PCNT_LAST) begin
                pcnt  <= '0;
                phase <= phase + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign slot_start = (cyc == '0);
    assign slot_end   = (cyc == CYC_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : seg_scan_controller
//  Purpose : Multiplexed 7-segment driver for NUM_DIGITS common-anode digits
//            with raw/hex patterns, per-digit blanking, PWM brightness and an
//            anti-ghost guard interval. All pin outputs are registered.
//  Ports   : clk, rst    - clock, async active-high reset
//            digits_i    - raw pattern per digit {dp,g..a}, active-high
//            hex_i       - nibble per digit (hex_mode_i = 1)
//            hex_mode_i  - select decoded nibble, dp taken from digits_i
//            blank_i     - per-digit blank (anode never driven)
//            bright_i    - on-time (bright_i+1)/2**BRIGHT_W of a slot
//            seg, an     - segment / anode pins
//            scan_idx_o  - digit in the slot shown on seg/an
//            frame_o     - pulse at cycle 0 of the digit-0 slot
//  Rev     : 1.0  initial release
// ============================================================================
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BRIGHT_W       = 3,
    parameter int GUARD_CYC      = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUM_DIGITS-1:0][7:0]                           digits_i,
    input  logic [NUM_DIGITS-1:0][3:0]                           hex_i,
    input  logic                                                 hex_mode_i,
    input  logic [NUM_DIGITS-1:0]                                blank_i,
    input  logic [BRIGHT_W-1:0]                                  bright_i,
    output logic [7:0]                                           seg,
    output logic [NUM_DIGITS-1:0]                                an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx_o,
    output logic                                                 frame_o
);

    localparam int DIGIT_CYC = CLK_HZ / SCAN_HZ;
    localparam int PHASE_CYC = DIGIT_CYC >> BRIGHT_W;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W     = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      GUARD_C  = CNT_W'(GUARD_CYC);
    localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

    generate
        if ((DIGIT_CYC % (2 ** BRIGHT_W)) != 0) begin : g_chk_div
            $fatal(1, "DIGIT_CYC must be a multiple of 2**BRIGHT_W");
        end
        if (PHASE_CYC < 1) begin : g_chk_phase
            $fatal(1, "PHASE_CYC must be at least 1");
        end
        if (GUARD_CYC >= DIGIT_CYC) begin : g_chk_guard
            $fatal(1, "GUARD_CYC must be less than DIGIT_CYC");
        end
    endgenerate

    logic [CNT_W-1:0]    cyc;
    logic [BRIGHT_W-1:0] phase;
    logic                slot_start;
    logic                slot_end;

    seg_tick_gen #(
        .DIGIT_CYC (DIGIT_CYC),
        .PHASE_CYC (PHASE_CYC),
        .BRIGHT_W  (BRIGHT_W),
        .CNT_W     (CNT_W)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .cyc        (cyc),
        .phase      (phase),
        .slot_start (slot_start),
        .slot_end   (slot_end)
    );

    logic [IDX_W-1:0]    idx;
    seg_t                seg_q;
    logic                blank_q;
    logic [BRIGHT_W-1:0] bright_q;

    seg_t                pat_live;
    seg_t                seg_cur;
    logic                blank_cur;
    logic [BRIGHT_W-1:0] bright_cur;
    logic                an_on;
    logic [NUM_DIGITS-1:0] an_cur;

    // The snapshot registers load at cycle 0, but the output stage must
    // already show the new values in that same cycle, so cycle 0 bypasses
    // the snapshot and uses the live inputs.
    always_comb begin
        pat_live         = hex_mode_i ? hex_to_seg(hex_i[idx]) : digits_i[idx];
        pat_live[SEG_DP] = digits_i[idx][SEG_DP];

        seg_cur    = slot_start ? pat_live : seg_q;
        blank_cur  = slot_start ? blank_i[idx] : blank_q;
        bright_cur = (slot_start && (idx == '0)) ? bright_i : bright_q;

        an_on  = (cyc >= GUARD_C) && (phase <= bright_cur) && !blank_cur;
        an_cur = '0;
        if (an_on) begin
            an_cur[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            seg_q      <= '0;
            blank_q    <= 1'b1;
            bright_q   <= '0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            scan_idx_o <= '0;
            frame_o    <= 1'b0;
        end else begin
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (slot_start) begin
                seg_q   <= pat_live;
                blank_q <= blank_i[idx];
            end
            // Brightness only changes on a frame boundary.
            if (slot_start && (idx == '0)) begin
                bright_q <= bright_i;
            end
            seg        <= SEG_ACTIVE_LOW ? ~seg_cur : seg_cur;
            an         <= AN_ACTIVE_LOW ? ~an_cur : an_cur;
            scan_idx_o <= idx;
            frame_o    <= slot_start && (idx == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_seg_scan_controller
//  Purpose : Self-checking bench for seg_scan_controller (4 digits,
//            16-cycle slots, 4-cycle phases, 1-cycle guard, active-low pins).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_seg_scan_controller;

    localparam int N         = 4;
    localparam int DIGIT_CYC = 16;
    localparam int PHASE_CYC = 4;
    localparam int GUARD     = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0][7:0] digits_i = '0;
    logic [N-1:0][3:0] hex_i = '0;
    logic              hex_mode_i = 1'b0;
    logic [N-1:0]      blank_i = '0;
    logic [1:0]        bright_i = '0;
    logic [7:0]        seg;
    logic [N-1:0]      an;
    logic [1:0]        scan_idx_o;
    logic              frame_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS     (N),
        .CLK_HZ         (1600),
        .SCAN_HZ        (100),
        .BRIGHT_W       (2),
        .GUARD_CYC      (GUARD),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_i   (digits_i),
        .hex_i      (hex_i),
        .hex_mode_i (hex_mode_i),
        .blank_i    (blank_i),
        .bright_i   (bright_i),
        .seg        (seg),
        .an         (an),
        .scan_idx_o (scan_idx_o),
        .frame_o    (frame_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the run is a sequence of 16-cycle slots counted from
    // reset release; each slot shows digit (slot mod 4) using inputs taken
    // at the slot's first cycle. Outputs appear one clock later.
    // ------------------------------------------------------------------
    logic [7:0] hexseg [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int         t = 0;
    logic [7:0] snap_pat [N];
    logic       snap_blank [N];
    int         snap_bright = 0;
    logic [7:0] m_seg   = 8'hFF;
    logic [3:0] m_an    = 4'hF;
    int         m_idx   = 0;
    logic       m_frame = 1'b0;

    always @(posedge clk or posedge rst) begin
        int c, d;
        bit on;
        if (rst) begin
            t = 0; m_seg = 8'hFF; m_an = 4'hF; m_idx = 0; m_frame = 1'b0;
        end else begin
            c = t % DIGIT_CYC;
            d = (t / DIGIT_CYC) % N;
            if (c == 0) begin
                snap_pat[d]   = hex_mode_i ? {digits_i[d][7], hexseg[hex_i[d]][6:0]} : digits_i[d];
                snap_blank[d] = blank_i[d];
                if (d == 0) snap_bright = int'(bright_i);
            end
            on      = (c >= GUARD) && ((c / PHASE_CYC) <= snap_bright) && !snap_blank[d];
            m_seg   = ~snap_pat[d];
            m_an    = on ? ~(4'b0001 << d) : 4'hF;
            m_idx   = d;
            m_frame = (c == 0) && (d == 0);
            t++;
        end
    end

    always @(negedge clk) begin
        check("model_seg", {24'h0, seg}, {24'h0, m_seg});
        check("model_an", {28'h0, an}, {28'h0, m_an});
        check("model_idx", {30'h0, scan_idx_o}, m_idx);
        check("model_frame", {31'h0, frame_o}, {31'h0, m_frame});
        check("one_hot_an", ($countones(~an) <= 1), 1);
    end

    // ------------------------------------------------------------------
    // Table-driven frame vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic              hex_mode;
        logic [N-1:0][7:0] digits;
        logic [N-1:0][3:0] hex;
        logic [1:0]        bright;
        logic [N-1:0]      blank;
        logic [N-1:0][7:0] exp_seg;   // pin values (active-low)
        logic [N-1:0][4:0] exp_on;    // active-anode cycles per slot
    } vec_t;

    vec_t vecs [5];

    task automatic sync_frame();
        int n = 0;
        @(negedge clk);
        while (frame_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("frame_sync_timeout", (n < 200), 1);
    endtask

    task automatic count_on(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (an !== 4'hF) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        hex_mode_i = v.hex_mode;
        digits_i   = v.digits;
        hex_i      = v.hex;
        bright_i   = v.bright;
        blank_i    = v.blank;
        sync_frame();
        for (int s = 0; s < N; s++) begin
            logic [7:0] first_seg;
            int  on_cnt;
            bit  stable, other;
            first_seg = seg;
            on_cnt = 0; stable = 1; other = 0;
            check("vec_slot_idx", {30'h0, scan_idx_o}, s);
            for (int c = 0; c < DIGIT_CYC; c++) begin
                if (seg !== first_seg) stable = 0;
                if (an[s] === 1'b0) on_cnt++;
                if ((an | (4'b0001 << s)) !== 4'hF) other = 1;
                @(negedge clk);
            end
            check("vec_seg", {24'h0, first_seg}, {24'h0, v.exp_seg[s]});
            check("vec_seg_stable", stable, 1);
            check("vec_on_cycles", on_cnt, {27'h0, v.exp_on[s]});
            check("vec_other_anode", other, 0);
        end
    endtask

    initial begin : main
        int cnt;

        vecs[0] = '{1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66}, '0, 2'd3, 4'b0000,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99}, {5'd15, 5'd15, 5'd15, 5'd15}};
        vecs[1] = '{1'b1, {8'h00, 8'h00, 8'h00, 8'h80}, {4'hF, 4'h0, 4'h9, 4'hA}, 2'd1, 4'b0000,
                    {8'h8E, 8'hC0, 8'h90, 8'h08}, {5'd7, 5'd7, 5'd7, 5'd7}};
        vecs[2] = '{1'b0, {8'h3F, 8'h06, 8'h80, 8'hFF}, '0, 2'd0, 4'b0000,
                    {8'hC0, 8'hF9, 8'h7F, 8'h00}, {5'd3, 5'd3, 5'd3, 5'd3}};
        vecs[3] = '{1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66}, '0, 2'd2, 4'b0100,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99}, {5'd11, 5'd0, 5'd11, 5'd11}};
        vecs[4] = '{1'b1, {8'h80, 8'h80, 8'h80, 8'h80}, {4'hC, 4'hE, 4'hB, 4'hD}, 2'd3, 4'b1001,
                    {8'h46, 8'h06, 8'h03, 8'h21}, {5'd0, 5'd15, 5'd15, 5'd0}};

        // Reset held for 5 clocks: outputs inactive throughout.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_seg", {24'h0, seg}, 32'hFF);
            check("rst_an", {28'h0, an}, 32'hF);
            check("rst_frame", {31'h0, frame_o}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_frame", {31'h0, frame_o}, 1);
        check("first_idx", {30'h0, scan_idx_o}, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Brightness change mid-frame only takes effect at the next frame.
        hex_mode_i = 1'b0; blank_i = '0; bright_i = 2'd3;
        digits_i = {8'h06, 8'h5B, 8'h4F, 8'h66};
        sync_frame();
        repeat (DIGIT_CYC + 5) @(negedge clk);
        bright_i = 2'd0;
        repeat (DIGIT_CYC - 5) @(negedge clk);
        count_on(2 * DIGIT_CYC, cnt);
        check("bright_hold_frame", cnt, 30);
        check("bright_next_frame_pulse", {31'h0, frame_o}, 1);
        count_on(N * DIGIT_CYC, cnt);
        check("bright_new_duty", cnt, 12);

        // Asynchronous reset at cycle 9 of slot 2.
        bright_i = 2'd3;
        sync_frame();
        repeat (2 * DIGIT_CYC + 9) @(negedge clk);
        check("pre_rst_idx", {30'h0, scan_idx_o}, 2);
        #1 rst = 1'b1;
        #1;
        check("async_rst_seg", {24'h0, seg}, 32'hFF);
        check("async_rst_an", {28'h0, an}, 32'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_frame", {31'h0, frame_o}, 1);
        check("restart_idx", {30'h0, scan_idx_o}, 0);

        // Randomized inputs checked against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                digits_i   = {$urandom};
                hex_i      = 16'($urandom);
                hex_mode_i = 1'($urandom);
                blank_i    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                bright_i   = 2'($urandom);
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
